// File: rtl/i2c_master_byte.sv
// Single-byte I2C bus master: START, 7-bit address + R/W, one data byte, ACK/NACK, STOP.
// Optional macro I2C_MASTER_CLK_STRETCH_EN: stall the SCL-high quarter while a slave holds SCL low.
module i2c_master_byte #(
    parameter int         CLK_DIV     = 250,
    parameter logic [6:0] I2C_ADR_DEF = 7'b1111111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic       dev_adr_sel,
    input  logic [6:0] dev_adr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    inout  wire        SDA,
    inout  wire        SCL
);

    localparam int            CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, WRITE, WACK, READ, MNACK, STOP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    adr_q, adr_d;
    logic [7:0]    wdat_q, wdat_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ack_err_q, ack_err_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          sda_oe_q, sda_oe_d;
    logic          scl_oe_q, scl_oe_d;
    logic          sda_in;
    logic          stall;
    logic          qend;

    assign sda_in = SDA;

`ifdef I2C_MASTER_CLK_STRETCH_EN
    logic [1:0] scl_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scl_sync_q <= 2'b11;
        else        scl_sync_q <= {scl_sync_q[0], SCL};
    end

    // Hold on the last q2 count so the synchronizer delay after our own release is absorbed.
    assign stall = (state_q != IDLE) && (qtr_q == 2'd2) && (cnt_q == CNT_MAX) && !scl_sync_q[1];
`else
    assign stall = 1'b0;
`endif

    assign qend = (cnt_q == CNT_MAX) && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rdata_q   <= '0;
            sda_oe_q  <= 1'b0;
            scl_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            rdata_q   <= rdata_d;
            sda_oe_q  <= sda_oe_d;
            scl_oe_q  <= scl_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        rdata_d   = rdata_q;

        if (state_q == IDLE) begin
            cnt_d = '0;
            qtr_d = '0;
            bit_d = '0;
            // The done cycle is still the tail of the old transaction; refuse start there.
            if (start && !done_q) begin
                state_d   = START;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
                adr_d     = {(dev_adr_sel ? dev_adr : I2C_ADR_DEF), rw};
                wdat_d    = wdata;
            end
        end else begin
            if (!stall) cnt_d = qend ? '0 : cnt_q + 1'b1;
            if (qend)   qtr_d = qtr_q + 2'd1;

            if (qend && qtr_q == 2'd2) begin
                case (state_q)
                    AACK:    ack_err_d = sda_in;
                    WACK:    if (sda_in) ack_err_d = 1'b1;
                    READ:    rdata_d = {rdata_q[6:0], sda_in};
                    default: ;
                endcase
            end

            if (qend && qtr_q == 2'd3) begin
                bit_d = '0;
                case (state_q)
                    START: state_d = ADDR;
                    ADDR: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = AACK;
                    end
                    AACK:  state_d = ack_err_q ? STOP : (adr_q[0] ? READ : WRITE);
                    WRITE: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = WACK;
                    end
                    WACK:  state_d = STOP;
                    READ: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = MNACK;
                    end
                    MNACK: state_d = STOP;
                    STOP: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Line enables are decoded from the next position so the registered pins line up with state_q.
    always_comb begin
        sda_oe_d = 1'b0;
        scl_oe_d = 1'b0;
        case (state_d)
            START: sda_oe_d = qtr_d[1];
            ADDR: begin
                scl_oe_d = !qtr_d[1];
                sda_oe_d = !adr_d[~bit_d];
            end
            WRITE: begin
                scl_oe_d = !qtr_d[1];
                sda_oe_d = !wdat_d[~bit_d];
            end
            AACK, WACK, READ, MNACK: scl_oe_d = !qtr_d[1];
            STOP: begin
                scl_oe_d = (qtr_d == 2'd0);
                sda_oe_d = (qtr_d != 2'd3);
            end
            default: ;
        endcase
    end

    assign SDA     = sda_oe_q ? 1'b0 : 1'bz;
    assign SCL     = scl_oe_q ? 1'b0 : 1'bz;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte with a clocked open-drain slave model on a pulled-up bus.
module tb_i2c_master_byte;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic       dev_adr_sel = 1'b0;
    logic [6:0] dev_adr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, ack_err;
    logic [7:0] rdata;
    wire        sda_bus, scl_bus;

    logic       sl_sda_lo = 1'b0;
    logic       sl_scl_lo = 1'b0;
    logic       sl_present = 1'b1;
    logic [7:0] sl_rbyte = '0;

    assign sda_bus = sl_sda_lo ? 1'b0 : 1'bz;
    assign scl_bus = sl_scl_lo ? 1'b0 : 1'bz;
    pullup (sda_bus);
    pullup (scl_bus);

    i2c_master_byte #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .dev_adr_sel(dev_adr_sel),
        .dev_adr(dev_adr), .wdata(wdata), .busy(busy), .done(done), .ack_err(ack_err),
        .rdata(rdata), .SDA(sda_bus), .SCL(scl_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: logs SDA at every SCL rise, drives ACK / read data after each SCL fall.
    logic        scl_p = 1'b1, sda_p = 1'b1;
    int          nb = 0, n_start = 0, n_stop = 0;
    logic [31:0] logb = '0;

    always @(negedge clk) begin
        scl_p <= scl_bus;
        sda_p <= sda_bus;
        if (scl_p && scl_bus && sda_p && !sda_bus) begin
            n_start   <= n_start + 1;
            nb        <= 0;
            sl_sda_lo <= 1'b0;
        end else if (scl_p && scl_bus && !sda_p && sda_bus) begin
            n_stop <= n_stop + 1;
        end else if (!scl_p && scl_bus) begin
            if (nb < 32) logb[nb] <= sda_bus;
            nb <= nb + 1;
        end else if (scl_p && !scl_bus) begin
            sl_sda_lo <= 1'b0;
            if (nb == 8)                                    sl_sda_lo <= sl_present;
            else if (nb >= 9 && nb <= 16 && logb[7])        sl_sda_lo <= sl_present && !sl_rbyte[16-nb];
            else if (nb == 17 && !logb[7])                  sl_sda_lo <= sl_present;
        end
    end

    int n_cmp = 0, n_bad = 0;
    int t0 = 0, lat = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = logb[s+i];
        return b;
    endfunction

    task automatic launch(input logic r, input logic sel, input logic [6:0] a, input logic [7:0] d);
        rw = r; dev_adr_sel = sel; dev_adr = a; wdata = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        chk("busy_rise", busy, 1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk({tag, "_done_seen"}, done, 1);
        lat = cyc - t0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_sda", sda_bus, 1);
        chk("rst_scl", scl_bus, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // write A5 to default address
        sl_present = 1'b1;
        launch(1'b0, 1'b0, 7'h00, 8'hA5);
        wait_done("t1");
        chk("t1_latency", lat, 320);
        chk("t1_ack_err", ack_err, 0);
        chk("t1_addr_bits", byte_at(0), 8'hFE);
        chk("t1_aack", logb[8], 0);
        chk("t1_data_bits", byte_at(9), 8'hA5);
        chk("t1_wack", logb[17], 0);
        chk("t1_scl_rises", nb, 19);
        chk("t1_starts", n_start, 1);
        chk("t1_stops", n_stop, 1);
        repeat (4) @(negedge clk);

        // read 3C from 2A
        sl_rbyte = 8'h3C;
        launch(1'b1, 1'b1, 7'h2A, 8'h00);
        wait_done("t2");
        chk("t2_latency", lat, 320);
        chk("t2_addr_bits", byte_at(0), 8'h55);
        chk("t2_aack", logb[8], 0);
        chk("t2_rdata", rdata, 8'h3C);
        chk("t2_master_nack", logb[17], 1);
        chk("t2_ack_err", ack_err, 0);
        chk("t2_stops", n_stop, 2);
        repeat (4) @(negedge clk);

        // no slave: address NACK
        sl_present = 1'b0;
        launch(1'b0, 1'b0, 7'h00, 8'hFF);
        wait_done("t3");
        chk("t3_latency", lat, 176);
        chk("t3_ack_err", ack_err, 1);
        chk("t3_aack_bit", logb[8], 1);
        chk("t3_scl_rises", nb, 10);
        chk("t3_stops", n_stop, 3);
        repeat (4) @(negedge clk);
        chk("t3_ack_err_held", ack_err, 1);

        // start held high through a whole transaction with changing fields
        sl_present = 1'b1;
        launch(1'b0, 1'b1, 7'h12, 8'h81);
        rw = 1'b1; dev_adr_sel = 1'b0; dev_adr = 7'h6D; wdata = 8'h7E; start = 1'b1;
        wait_done("t4a");
        chk("t4a_latency", lat, 320);
        chk("t4a_addr_bits", byte_at(0), 8'h24);
        chk("t4a_data_bits", byte_at(9), 8'h81);
        chk("t4a_ack_err", ack_err, 0);
        rw = 1'b0; dev_adr_sel = 1'b1; dev_adr = 7'h55; wdata = 8'hC3;
        @(negedge clk);
        chk("t4_start_at_done_ignored", busy, 0);
        @(negedge clk);
        chk("t4_start_in_idle_taken", busy, 1);
        start = 1'b0;
        t0 = cyc;
        wait_done("t4b");
        chk("t4b_latency", lat, 320);
        chk("t4b_addr_bits", byte_at(0), 8'hAA);
        chk("t4b_data_bits", byte_at(9), 8'hC3);
        repeat (4) @(negedge clk);

        // reset during WRITE bit 6 (a 0 bit, SCL low)
        launch(1'b0, 1'b0, 7'h00, 8'hA5);
        repeat (178) @(negedge clk);
        chk("t5_pre_scl_low", scl_bus, 0);
        chk("t5_pre_sda_low", sda_bus, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_sda_released", sda_bus, 1);
        chk("t5_scl_released", scl_bus, 1);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        launch(1'b0, 1'b0, 7'h00, 8'h5A);
        wait_done("t5b");
        chk("t5b_latency", lat, 320);
        chk("t5b_addr_bits", byte_at(0), 8'hFE);
        chk("t5b_data_bits", byte_at(9), 8'h5A);
        chk("t5b_ack_err", ack_err, 0);
        repeat (4) @(negedge clk);

        // slave holds SCL low 20 clocks from the SCL-high quarter of address bit 3
        sl_present = 1'b0;
        launch(1'b0, 1'b0, 7'h00, 8'h00);
        repeat (72) @(negedge clk);
        #1 sl_scl_lo = 1'b1;
        repeat (20) @(negedge clk);
        #1 sl_scl_lo = 1'b0;
        wait_done("t6");
`ifdef I2C_MASTER_CLK_STRETCH_EN
        chk("t6_latency", lat, 195);
`else
        chk("t6_latency", lat, 176);
`endif
        chk("t6_ack_err", ack_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
